// File: rtl/led_ctrl_pkg.sv
// Shared constants, FSM state type and snapshot byte selector for the LED grid serializer.
package led_ctrl_pkg;

   localparam int GRID_BITS    = 256;
   localparam int BYTES_PER_CH = 16;
   localparam int CH_BITS      = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Byte k of channel ch: bit offset is ch*128 + k*8, built by concatenation.
   function automatic logic [7:0] chan_byte(input logic [GRID_BITS-1:0] img,
                                            input logic                 ch,
                                            input logic [3:0]           k);
      return img[{ch, k, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous strobe followed by a registered rising-edge pulse.
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic din,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   last_q;

   // The pulse is registered, so a strobe edge reaches the channel logic SYNC_STAGES+1 clocks later.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         last_q <= 1'b0;
         rise   <= 1'b0;
      end else begin
         sync_q <= (sync_q << 1) | SYNC_STAGES'(din);
         last_q <= sync_q[SYNC_STAGES-1];
         rise   <= sync_q[SYNC_STAGES-1] & ~last_q;
      end
   end

endmodule

// File: rtl/led_controller_final.sv
// Snapshots a 256-bit LED image and streams 16 bytes on each of two strobe-paced channels.
//
// state | meaning
// IDLE  | outputs 0, waiting for a registered rising edge of ledstart
// RUN   | channels advance on their synchronized strobes until both are done
// DONE  | single cycle, finished = 1, then back to IDLE
module led_controller_final #(
   parameter int BYTES_PER_CH = 16,
   parameter int SYNC_STAGES  = 2
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         arduinoClock,
   input  logic         arduinoClock2,
   input  logic         ledstart,
   input  logic [255:0] values,
   output logic [7:0]   ledOut,
   output logic [7:0]   ledOut2,
   output logic         arduinoStart,
   output logic         arduinoStart2,
   output logic         finished
);

   import led_ctrl_pkg::*;

   localparam logic [4:0] LAST_IDX = 5'(BYTES_PER_CH);

   state_t                 state_q, state_d;
   logic                   start_q, start_pulse_q;
   logic [GRID_BITS-1:0]   snap_q;
   logic [4:0]             idx0_q, idx1_q;
   logic [4:0]             idx0_next, idx1_next;
   logic                   rise0, rise1;
   logic                   adv0, adv1;
   logic                   launch;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync0 (
      .clock   (clock),
      .reset_n (reset_n),
      .din     (arduinoClock),
      .rise    (rise0)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
      .clock   (clock),
      .reset_n (reset_n),
      .din     (arduinoClock2),
      .rise    (rise1)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      launch    = 1'b0;
      adv0      = 1'b0;
      adv1      = 1'b0;
      idx0_next = idx0_q + 5'd1;
      idx1_next = idx1_q + 5'd1;
      case (state_q)
         IDLE: begin
            if (start_pulse_q) begin
               state_d = RUN;
               launch  = 1'b1;
            end
         end
         RUN: begin
            adv0 = rise0 & arduinoStart;
            adv1 = rise1 & arduinoStart2;
            if (!arduinoStart && !arduinoStart2) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Start is edge-detected on registered copies, which puts the launch one clock after sampling.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         start_q       <= 1'b0;
         start_pulse_q <= 1'b0;
         finished      <= 1'b0;
      end else begin
         start_q       <= ledstart;
         start_pulse_q <= ledstart & ~start_q;
         finished      <= (state_d == DONE);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         snap_q        <= '0;
         idx0_q        <= '0;
         idx1_q        <= '0;
         arduinoStart  <= 1'b0;
         arduinoStart2 <= 1'b0;
         ledOut        <= '0;
         ledOut2       <= '0;
      end else if (launch) begin
         snap_q        <= values;
         idx0_q        <= '0;
         idx1_q        <= '0;
         arduinoStart  <= 1'b1;
         arduinoStart2 <= 1'b1;
         ledOut        <= chan_byte(values, 1'b0, 4'd0);
         ledOut2       <= chan_byte(values, 1'b1, 4'd0);
      end else begin
         if (adv0) begin
            idx0_q <= idx0_next;
            if (idx0_next == LAST_IDX) begin
               arduinoStart <= 1'b0;
               ledOut       <= '0;
            end else begin
               ledOut <= chan_byte(snap_q, 1'b0, idx0_next[3:0]);
            end
         end
         if (adv1) begin
            idx1_q <= idx1_next;
            if (idx1_next == LAST_IDX) begin
               arduinoStart2 <= 1'b0;
               ledOut2       <= '0;
            end else begin
               ledOut2 <= chan_byte(snap_q, 1'b1, idx1_next[3:0]);
            end
         end
      end
   end

endmodule

// File: tb/tb_led_controller_final.sv
// Self-checking bench for led_controller_final: vector table, hand corner sequences, random strobe order.
module tb_led_controller_final;

   logic         clock = 1'b0;
   logic         reset_n;
   logic         arduinoClock;
   logic         arduinoClock2;
   logic         ledstart;
   logic [255:0] values;
   logic [7:0]   ledOut;
   logic [7:0]   ledOut2;
   logic         arduinoStart;
   logic         arduinoStart2;
   logic         finished;

   led_controller_final dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .arduinoClock  (arduinoClock),
      .arduinoClock2 (arduinoClock2),
      .ledstart      (ledstart),
      .values        (values),
      .ledOut        (ledOut),
      .ledOut2       (ledOut2),
      .arduinoStart  (arduinoStart),
      .arduinoStart2 (arduinoStart2),
      .finished      (finished)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;
   int fin_total = 0;

   always @(negedge clock) begin
      if (finished === 1'b1) fin_total = fin_total + 1;
   end

   // Reference model: the captured image plus how many bytes each channel has consumed.
   logic [255:0] img_m;
   int           k0, k1;
   bit           run_m;

   typedef struct {
      int n0;
      int n1;
      bit s0;
      bit s1;
      int fin;
   } vec_t;

   function automatic logic [7:0] exp_byte(input logic [255:0] img, input int ch, input int k);
      if (!run_m || k >= 16) return 8'h00;
      return img[ch*128 + k*8 +: 8];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests = tests + 1;
      if (act !== exp) begin
         fails = fails + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_chan(input string tag);
      check({tag, "_led0"},   32'(ledOut),        32'(exp_byte(img_m, 0, k0)));
      check({tag, "_led1"},   32'(ledOut2),       32'(exp_byte(img_m, 1, k1)));
      check({tag, "_start0"}, 32'(arduinoStart),  32'(run_m && k0 < 16));
      check({tag, "_start1"}, 32'(arduinoStart2), 32'(run_m && k1 < 16));
   endtask

   task automatic pulse(input bit c0, input bit c1);
      @(negedge clock);
      arduinoClock  = c0;
      arduinoClock2 = c1;
      repeat (4) @(negedge clock);
      arduinoClock  = 1'b0;
      arduinoClock2 = 1'b0;
      repeat (4) @(negedge clock);
      if (run_m && c0 && k0 < 16) k0 = k0 + 1;
      if (run_m && c1 && k1 < 16) k1 = k1 + 1;
      if (run_m && k0 == 16 && k1 == 16) run_m = 0;
   endtask

   task automatic start_xfer(input string tag);
      @(negedge clock);
      ledstart = 1'b1;
      @(negedge clock);
      check({tag, "_start_not_yet"}, 32'(arduinoStart), 32'd0);
      @(negedge clock);
      img_m = values;
      k0 = 0;
      k1 = 0;
      run_m = 1;
      check_chan({tag, "_launch"});
      ledstart = 1'b0;
   endtask

   function automatic logic [255:0] rand_img();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs[2];
      int   f0;
      int   iter;

      vecs[0] = '{n0: 16, n1: 5,  s0: 1'b0, s1: 1'b1, fin: 0};
      vecs[1] = '{n0: 0,  n1: 10, s0: 1'b0, s1: 1'b1, fin: 0};

      reset_n = 1'b0;
      arduinoClock = 1'b0;
      arduinoClock2 = 1'b0;
      ledstart = 1'b0;
      values = '0;
      img_m = '0;
      k0 = 0;
      k1 = 0;
      run_m = 0;
      repeat (3) @(negedge clock);
      check_chan("reset");
      check("reset_finished", 32'(finished), 32'd0);
      reset_n = 1'b1;

      // Strobes in IDLE must be ignored.
      f0 = fin_total;
      for (int i = 0; i < 10; i++) pulse(1'b1, 1'b1);
      check_chan("idle_strobe");
      check("idle_finished", 32'(fin_total - f0), 32'd0);

      // Basic transfer with byte k = k.
      for (int i = 0; i < 32; i++) values[i*8 +: 8] = 8'(i);
      f0 = fin_total;
      start_xfer("basic");
      @(negedge clock);
      arduinoClock  = 1'b1;
      arduinoClock2 = 1'b1;
      repeat (3) @(negedge clock);
      check("strobe_lat_early0", 32'(ledOut),  32'(exp_byte(img_m, 0, 0)));
      check("strobe_lat_early1", 32'(ledOut2), 32'(exp_byte(img_m, 1, 0)));
      @(negedge clock);
      k0 = 1;
      k1 = 1;
      check_chan("strobe_lat");
      repeat (3) @(negedge clock);
      arduinoClock  = 1'b0;
      arduinoClock2 = 1'b0;
      repeat (4) @(negedge clock);
      for (int i = 1; i < 16; i++) begin
         pulse(1'b1, 1'b1);
         check_chan($sformatf("basic_b%0d", i));
      end
      check("basic_finished_once", 32'(fin_total - f0), 32'd1);

      // Skewed channels: table of strobe bursts, then the last channel-1 edge by hand.
      values = rand_img();
      f0 = fin_total;
      start_xfer("skew");
      for (int v = 0; v < 2; v++) begin
         for (int i = 0; i < vecs[v].n0; i++) pulse(1'b1, 1'b0);
         for (int i = 0; i < vecs[v].n1; i++) pulse(1'b0, 1'b1);
         check_chan($sformatf("skew_v%0d", v));
         check($sformatf("skew_v%0d_s0", v), 32'(arduinoStart),  32'(vecs[v].s0));
         check($sformatf("skew_v%0d_s1", v), 32'(arduinoStart2), 32'(vecs[v].s1));
         check($sformatf("skew_v%0d_fin", v), 32'(fin_total - f0), 32'(vecs[v].fin));
      end
      @(negedge clock);
      arduinoClock2 = 1'b1;
      repeat (4) @(negedge clock);
      check("skew_last_drop", 32'(arduinoStart2), 32'd0);
      check("skew_fin_not_yet", 32'(finished), 32'd0);
      @(negedge clock);
      check("skew_fin_pulse", 32'(finished), 32'd1);
      @(negedge clock);
      check("skew_fin_clear", 32'(finished), 32'd0);
      arduinoClock2 = 1'b0;
      repeat (4) @(negedge clock);
      k1 = 16;
      run_m = 0;
      check("skew_fin_once", 32'(fin_total - f0), 32'd1);

      // Snapshot isolation with random strobe ordering.
      values = rand_img();
      f0 = fin_total;
      start_xfer("snap");
      values = '1;
      iter = 0;
      while (run_m && iter < 200) begin
         bit c0, c1;
         c0 = 1'($urandom_range(0, 1));
         c1 = 1'($urandom_range(0, 1));
         if (c0 || c1) begin
            pulse(c0, c1);
            check_chan($sformatf("snap_i%0d", iter));
         end
         iter++;
      end
      check("snap_completed", 32'(run_m), 32'd0);
      check("snap_finished_once", 32'(fin_total - f0), 32'd1);

      // Second start edge during RUN is ignored.
      values = rand_img();
      f0 = fin_total;
      start_xfer("ign");
      for (int i = 0; i < 3; i++) pulse(1'b1, 1'b1);
      @(negedge clock);
      ledstart = 1'b1;
      repeat (4) @(negedge clock);
      ledstart = 1'b0;
      repeat (3) @(negedge clock);
      check_chan("ign_restart");
      for (int i = 0; i < 13; i++) pulse(1'b1, 1'b1);
      check_chan("ign_done");
      check("ign_finished_once", 32'(fin_total - f0), 32'd1);
      values = rand_img();
      start_xfer("fresh");

      // Asynchronous reset mid-transfer aborts with no finished pulse.
      for (int i = 0; i < 4; i++) pulse(1'b1, 1'b1);
      check_chan("pre_reset");
      f0 = fin_total;
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      run_m = 0;
      check_chan("reset_async");
      check("reset_async_fin", 32'(finished), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) pulse(1'b1, 1'b1);
      check_chan("post_reset");
      check("post_reset_fin", 32'(fin_total - f0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
